// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bundle, runs loads/stores on a req/ready port, emits a WB bundle.
// Optional: MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap pulse instead of truncation.
module mem_stage #(
    parameter int unsigned     XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc_from_ex,
    input  logic [XLEN-1:0] c,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      reg_wr_addr,
    input  logic            jump_or_branch,
    output logic            stall,
    output logic            redirect,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state_q, state_d;

    logic            mem_req_d, mem_we_d, wb_valid_d, wb_we_d, redirect_d;
    logic [XLEN-1:0] mem_addr_d, mem_wdata_d, wb_data_d;
    logic [3:0]      mem_be_d;
    logic [4:0]      wb_rd_d;

    // Access attributes kept for the load-extension on completion
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;

    logic [1:0]      off, size;
    logic            is_load, is_store, is_mem, is_link, writes_rd, misalign_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c, load_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;

    assign off       = c[1:0];
    assign size      = funct3[1:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_mem    = is_load | is_store;
    assign is_link   = (opcode == OP_JAL) | (opcode == OP_JALR);
    assign writes_rd = (opcode == OP_LUI) | (opcode == OP_AUIPC) | is_link |
                       (opcode == OP_OP) | (opcode == OP_OPIMM);

    assign stall = (state_q == ACCESS) && !mem_ready;

`ifdef MISALIGN_TRAP_EN
    logic misaligned_d;
    assign misalign_c = ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
`else
    assign misalign_c = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Byte enables and lane-replicated store data; sizes 10/11 behave as word
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = b;
        case (size)
            2'b00: begin
                be_c    = 4'(4'b0001 << off);
                wdata_c = {4{b[7:0]}};
            end
            2'b01: begin
                be_c    = off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{b[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension from the registered offset/funct3
    always_comb begin
        byte_c = mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_c = mem_rdata[15:8];
            2'd2:    byte_c = mem_rdata[23:16];
            2'd3:    byte_c = mem_rdata[31:24];
            default: byte_c = mem_rdata[7:0];
        endcase
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            3'b100:  load_c = {{(XLEN-8){1'b0}}, byte_c};
            3'b001:  load_c = {{(XLEN-16){half_c[15]}}, half_c};
            3'b101:  load_c = {{(XLEN-16){1'b0}}, half_c};
            default: load_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= RESET_PC_LINK;
            redirect  <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            rd_q      <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
            wb_valid  <= wb_valid_d;
            wb_we     <= wb_we_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            redirect  <= redirect_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
`ifdef MISALIGN_TRAP_EN
            misaligned <= misaligned_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_valid && is_mem && !misalign_c) state_d = ACCESS;
            ACCESS:  if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; bus fields hold unless a request starts
    always_comb begin
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_data;
        redirect_d  = 1'b0;
        f3_d        = f3_q;
        off_d       = off_q;
        rd_d        = rd_q;
`ifdef MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    redirect_d = jump_or_branch;
                    if (is_mem && misalign_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = reg_wr_addr;
`ifdef MISALIGN_TRAP_EN
                        misaligned_d = 1'b1;
`endif
                    end else if (is_mem) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {c[XLEN-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                        f3_d        = funct3;
                        off_d       = off;
                        rd_d        = reg_wr_addr;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = reg_wr_addr;
                        wb_we_d    = writes_rd && (reg_wr_addr != 5'd0);
                        wb_data_d  = is_link ? pc_from_ex + XLEN'(4) : c;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = !mem_we && (rd_q != 5'd0);
                    if (!mem_we) wb_data_d = load_c;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU/jump retire, stores, loads with extension, misalignment, reset mid-access.
module tb_mem_stage;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [31:0] LINK_RST = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, jump_or_branch, mem_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc_from_ex, c, b, mem_rdata;
    logic [4:0]  reg_wr_addr;
    logic        stall, redirect, mem_req, mem_we, wb_valid, wb_we, misaligned;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_be;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    mem_stage #(.XLEN(32), .RESET_PC_LINK(LINK_RST)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .opcode(opcode), .funct3(funct3),
        .pc_from_ex(pc_from_ex), .c(c), .b(b), .reg_wr_addr(reg_wr_addr),
        .jump_or_branch(jump_or_branch), .stall(stall), .redirect(redirect),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one bundle for a single accepting edge; returns at the following negedge
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] cv, input logic [31:0] bv, input logic [4:0] rd,
                         input logic jb);
        opcode = op; funct3 = f3; pc_from_ex = pc; c = cv; b = bv;
        reg_wr_addr = rd; jump_or_branch = jb; ex_valid = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0; jump_or_branch = 1'b0;
        @(negedge clk);
    endtask

    // Raise mem_ready for one cycle from an ACCESS negedge
    task automatic complete(input logic [31:0] rdata);
        mem_rdata = rdata; mem_ready = 1'b1;
        #1 chk("stall_on_ready", 32'(stall), 32'd0);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; jump_or_branch = 1'b0; mem_ready = 1'b0;
        opcode = '0; funct3 = '0; pc_from_ex = '0; c = '0; b = '0; reg_wr_addr = '0;
        mem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, LINK_RST);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU result retire, then rd=0 suppresses the write
        issue(OP_OP, 3'b000, 32'h0, 32'h0000_0005, 32'h0, 5'd3, 1'b0);
        chk("add_wb_valid", 32'(wb_valid), 32'd1);
        chk("add_wb_we", 32'(wb_we), 32'd1);
        chk("add_wb_rd", 32'(wb_rd), 32'd3);
        chk("add_wb_data", wb_data, 32'h0000_0005);
        issue(OP_OP, 3'b000, 32'h0, 32'h0000_0007, 32'h0, 5'd0, 1'b0);
        chk("add_rd0_valid", 32'(wb_valid), 32'd1);
        chk("add_rd0_we", 32'(wb_we), 32'd0);
        idle_cycle();
        chk("wb_valid_pulse", 32'(wb_valid), 32'd0);

        // JAL link value and redirect pulse
        issue(OP_JAL, 3'b000, 32'h0000_0100, 32'h0000_0200, 32'h0, 5'd1, 1'b1);
        chk("jal_wb_data", wb_data, 32'h0000_0104);
        chk("jal_wb_we", 32'(wb_we), 32'd1);
        chk("jal_redirect", 32'(redirect), 32'd1);
        idle_cycle();
        chk("jal_redirect_pulse", 32'(redirect), 32'd0);

        // Taken branch: no write, redirect
        issue(OP_BRANCH, 3'b000, 32'h0000_0200, 32'h0, 32'h0, 5'd0, 1'b1);
        chk("br_wb_valid", 32'(wb_valid), 32'd1);
        chk("br_wb_we", 32'(wb_we), 32'd0);
        chk("br_redirect", 32'(redirect), 32'd1);

        // SB at offset 3, ready on the third ACCESS cycle
        issue(OP_STORE, 3'b000, 32'h0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 1'b0);
        chk("sb_mem_req", 32'(mem_req), 32'd1);
        chk("sb_mem_we", 32'(mem_we), 32'd1);
        chk("sb_mem_addr", mem_addr, 32'h0000_1000);
        chk("sb_mem_be", 32'(mem_be), 32'b1000);
        chk("sb_mem_wdata", mem_wdata, 32'hDDDD_DDDD);
        chk("sb_stall_1", 32'(stall), 32'd1);
        idle_cycle();
        chk("sb_stall_2", 32'(stall), 32'd1);
        chk("sb_addr_held", mem_addr, 32'h0000_1000);
        chk("sb_wb_idle", 32'(wb_valid), 32'd0);
        complete(32'h0);
        chk("sb_req_drop", 32'(mem_req), 32'd0);
        chk("sb_wb_valid", 32'(wb_valid), 32'd1);
        chk("sb_wb_we", 32'(wb_we), 32'd0);

        // Byte / half loads with sign and zero extension
        issue(OP_LOAD, 3'b000, 32'h0, 32'h0000_2002, 32'h0, 5'd5, 1'b0);
        chk("lb_mem_we", 32'(mem_we), 32'd0);
        chk("lb_mem_addr", mem_addr, 32'h0000_2000);
        chk("lb_mem_be", 32'(mem_be), 32'b0100);
        complete(32'h0080_0000);
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_wb_we", 32'(wb_we), 32'd1);
        chk("lb_wb_rd", 32'(wb_rd), 32'd5);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        issue(OP_LOAD, 3'b100, 32'h0, 32'h0000_2002, 32'h0, 5'd6, 1'b0);
        complete(32'h0080_0000);
        chk("lbu_wb_data", wb_data, 32'h0000_0080);
        issue(OP_LOAD, 3'b001, 32'h0, 32'h0000_2002, 32'h0, 5'd7, 1'b0);
        chk("lh_mem_be", 32'(mem_be), 32'b1100);
        complete(32'h8001_0000);
        chk("lh_wb_data", wb_data, 32'hFFFF_8001);

        // LHU with ready already high: ignored in IDLE, 2-cycle latency, no stall
        mem_rdata = 32'h1234_F00D; mem_ready = 1'b1;
        issue(OP_LOAD, 3'b101, 32'h0, 32'h0000_4000, 32'h0, 5'd8, 1'b0);
        chk("lhu_req", 32'(mem_req), 32'd1);
        chk("lhu_no_stall", 32'(stall), 32'd0);
        idle_cycle();
        mem_ready = 1'b0;
        chk("lhu_wb_valid", 32'(wb_valid), 32'd1);
        chk("lhu_wb_data", wb_data, 32'h0000_F00D);
        chk("lhu_req_drop", 32'(mem_req), 32'd0);

        // SH at offset 2 and SW: lane enables and replication
        issue(OP_STORE, 3'b001, 32'h0, 32'h0000_4002, 32'h1234_ABCD, 5'd0, 1'b0);
        chk("sh_mem_be", 32'(mem_be), 32'b1100);
        chk("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        complete(32'h0);
        issue(OP_STORE, 3'b010, 32'h0, 32'h0000_4004, 32'h1234_ABCD, 5'd0, 1'b0);
        chk("sw_mem_be", 32'(mem_be), 32'b1111);
        chk("sw_mem_wdata", mem_wdata, 32'h1234_ABCD);
        complete(32'h0);

        // Back-to-back ALU bundles retire on consecutive cycles
        issue(OP_OP, 3'b000, 32'h0, 32'h0000_0011, 32'h0, 5'd9, 1'b0);
        chk("b2b_first", wb_data, 32'h0000_0011);
        issue(OP_OP, 3'b000, 32'h0, 32'h0000_0022, 32'h0, 5'd10, 1'b0);
        chk("b2b_second_valid", 32'(wb_valid), 32'd1);
        chk("b2b_second", wb_data, 32'h0000_0022);
        chk("b2b_second_rd", 32'(wb_rd), 32'd10);

        // Misaligned LW
        issue(OP_LOAD, 3'b010, 32'h0, 32'h0000_3002, 32'h0, 5'd11, 1'b0);
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_req", 32'(mem_req), 32'd0);
        chk("lw_mis_flag", 32'(misaligned), 32'd1);
        chk("lw_mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("lw_mis_wb_we", 32'(wb_we), 32'd0);
        idle_cycle();
        chk("lw_mis_pulse", 32'(misaligned), 32'd0);
`else
        chk("lw_trunc_req", 32'(mem_req), 32'd1);
        chk("lw_trunc_addr", mem_addr, 32'h0000_3000);
        chk("lw_trunc_be", 32'(mem_be), 32'b1111);
        chk("lw_misaligned_tied", 32'(misaligned), 32'd0);
        complete(32'h1234_5678);
        chk("lw_trunc_data", wb_data, 32'h1234_5678);
`endif

        // Reset while a load is outstanding, then normal retire
        issue(OP_LOAD, 3'b010, 32'h0, 32'h0000_5000, 32'h0, 5'd12, 1'b0);
        chk("mid_req", 32'(mem_req), 32'd1);
        chk("mid_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_wb_data", wb_data, LINK_RST);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_OP, 3'b000, 32'h0, 32'h0000_0009, 32'h0, 5'd4, 1'b0);
        chk("post_rst_valid", 32'(wb_valid), 32'd1);
        chk("post_rst_data", wb_data, 32'h0000_0009);
        chk("post_rst_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
